// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a first-word-fall-through receive FIFO
// and sticky error flags (frame_err, overrun, parity_err).
// Optional feature: define UART_RX_PARITY_EN to receive and check one parity
// bit per frame (sense selected by PARITY_ODD). Without it parity_err is 0.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          RXD,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    input  logic                          clr_err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state, state_nx;
    logic                   rx_meta, rx_s, rx_prev;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [BW-1:0]          bit_cnt, bit_nx;
    logic [DATA_BITS-1:0]   shift, shift_nx;
    logic                   stop_bad, stop_bad_nx;
    logic                   push_q, push_nx;
    logic                   ferr_set, perr_set;
    logic                   tick;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   full, pop, wr;

    assign tick = (cnt == '0);

    // Two-flop synchroniser plus the previous value for falling-edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            stop_bad <= 1'b0;
            push_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_cnt  <= bit_nx;
            shift    <= shift_nx;
            stop_bad <= stop_bad_nx;
            push_q   <= push_nx;
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit-period counter.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nx    = state;
        cnt_nx      = cnt;
        bit_nx      = bit_cnt;
        shift_nx    = shift;
        stop_bad_nx = stop_bad;
        push_nx     = 1'b0;
        ferr_set    = 1'b0;
        perr_set    = 1'b0;
        if (state != S_IDLE && !tick) cnt_nx = cnt - 1'b1;
        unique case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    cnt_nx   = HALF_LOAD;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DATA;
                        cnt_nx   = FULL_LOAD;
                        bit_nx   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_nx = {rx_s, shift[DATA_BITS-1:1]};
                    cnt_nx   = FULL_LOAD;
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_nx      = '0;
                        stop_bad_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_nx    = S_PARITY;
`else
                        state_nx    = S_STOP;
`endif
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    // Data plus parity bit must have even (or odd) weight.
                    perr_set    = ((^shift) ^ rx_s) != 1'(PARITY_ODD);
                    cnt_nx      = FULL_LOAD;
                    bit_nx      = '0;
                    stop_bad_nx = 1'b0;
                    state_nx    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    ferr_set = !rx_s;
                    if (!rx_s) stop_bad_nx = 1'b1;
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        push_nx  = rx_s && !stop_bad;
                        state_nx = S_IDLE;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                        cnt_nx = FULL_LOAD;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign full = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    assign pop  = rd_en && rd_valid;
    assign wr   = push_q && (!full || pop);

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; emptiness is tracked by the
        // count, and rd_data is masked while nothing is held.
        if (wr) mem[wr_ptr] <= shift;
    end

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Sticky flags: a set event in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set || (frame_err && !clr_err);
            overrun   <= (push_q && full && !pop) || (overrun && !clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag.
    always_ff @(posedge clk) begin
        if (!resetn) parity_err <= 1'b0;
        else         parity_err <= perr_set || (parity_err && !clr_err);
    end
`else
    // No parity bit on the line; PARITY_ODD has no effect in this build and is
    // folded into a constant zero only so it stays referenced.
    assign parity_err = 1'b0 & 1'(PARITY_ODD) & perr_set;
`endif

endmodule
